memory_playback_seq: RTL and testbench
======================================

// Module: memory_playback_seq
// PURPOSE
// - Reader/consumer side of the music memory unit: drives read_rst/read_en, captures data_out on output_ready,
//   decodes each word into note + length, holds the note for its duration, then fetches the next word.
// - Sits between the memory unit and the tone generator; serves AUTOPLAY/LEARNING/GAME playback.
// PARAMETERS
// - DATA_WIDTH      8           memory word width; word = {note[DATA_WIDTH-1:3], len[2:0]}
// - TICKS_PER_BEAT  12_500_000  clk cycles per beat (one length unit)
// - GAP_TICKS       1_000_000   muted articulation gap after each note (< TICKS_PER_BEAT)
// - READ_TIMEOUT    16          max cycles waiting for mem_ready after a read_en pulse
// PORTS
// - clk           in   1             system clock
// - rst           in   1             synchronous, active-high reset
// - start         in   1             pulse: rewind and start playback (ignored unless IDLE or DONE)
// - stop          in   1             pulse: abort, return to IDLE (priority over start/pause)
// - pause         in   1             level: freeze duration counting while high
// - mem_read_en   out  1             one-cycle read request to memory unit
// - mem_read_rst  out  1             one-cycle read-pointer rewind to memory unit
// - mem_data      in   DATA_WIDTH    memory unit data_out
// - mem_ready     in   1             memory unit output_ready
// - note_out      out  DATA_WIDTH-3  current note code; 0 = rest/silence
// - note_valid    out  1             high while note_out is sounding (PLAY, not paused)
// - beat_pulse    out  1             one-cycle pulse at each beat boundary during PLAY
// - busy          out  1             high in every state except IDLE and DONE
// - done          out  1             level, high in DONE
// - rd_error      out  1             sticky; set on read timeout, cleared by start or rst
// BEHAVIOUR
// - Clock/reset: one clock; reset is synchronous and active-high.
// - Reset values: all outputs 0; state IDLE; counters 0.
// - FSM: IDLE -start-> REWIND (mem_read_rst=1, 1 cycle) -> FETCH (mem_read_en=1, 1 cycle) -> WAIT.
// - WAIT: first cycle with mem_ready=1 latches mem_data. Word == all-ones (END) -> DONE.
//   Else note_out <= word[DATA_WIDTH-1:3], beats = len+1 (1..8) -> PLAY. Read-to-note latency: 1 cycle after ready.
// - WAIT timeout: READ_TIMEOUT cycles without ready -> rd_error=1, note_out=0 -> IDLE.
// - PLAY: tick counter 0..TICKS_PER_BEAT-1; wrap pulses beat_pulse and decrements beats; last beat wrap -> GAP.
//   note_valid=1 only in PLAY with pause=0; note code 0 keeps note_valid=0 (rest).
// - GAP: note_valid=0 for GAP_TICKS cycles -> FETCH. Tick/gap counters saturate-free: width $clog2(max+1).
// - pause=1 in PLAY/GAP: counters hold, note_valid=0, note_out held; release resumes same tick. Ignored elsewhere.
// - DONE: done=1, note_out=0; start -> REWIND (rd_error cleared). stop in any state -> IDLE, note_out=0,
//   no mem strobes that cycle. start and stop same cycle -> stop wins. rst mid-operation -> IDLE immediately.
// - mem_read_en and mem_read_rst never both high; each exactly one cycle per request.
// CONFIGURATION
// - PLAYBACK_LOOP_EN defined: END word -> REWIND (continuous loop), done never asserts, busy stays high.
// - PLAYBACK_LOOP_EN undefined: END word -> DONE as above.
// STRUCTURE
// - Shared package (memory parameters): DATA_WIDTH, END/REST word constants, note/len field positions,
//   playback FSM state encoding.
// - One sub-module: playback_beat_timer (tick counter, pause hold, beat_pulse, last-beat flag).
// TESTING (bench uses TICKS_PER_BEAT=4, GAP_TICKS=2, READ_TIMEOUT=5)
// - start; words 0x2A,0xFF with ready 1 cycle after read_en -> read_rst pulse, note_out=5 for 3x4=12 cycles, 3 beat_pulses, 2-cycle gap, done=1.
// - Word 0x01 (note 0, len 1) -> note_valid stays 0 for 8 cycles, beat_pulse twice, then next fetch.
// - pause high 3 cycles mid-PLAY -> note_valid=0, counter frozen, note ends 3 cycles later than nominal.
// - mem_ready never asserted -> after 5 WAIT cycles rd_error=1, state IDLE, note_out=0; next start clears rd_error.
// - stop and start same cycle during PLAY -> IDLE, note_out=0, no mem_read_en that cycle; rst mid-WAIT -> all outputs 0.
// - PLAYBACK_LOOP_EN: 0xFF word -> mem_read_rst pulse then first word replayed; done stays 0.

Source files
------------

// File: rtl/memory_playback_seq_pkg.sv
// Shared definitions for the music memory playback reader: word field layout,
// rest note code and the playback FSM state encoding.
package memory_playback_seq_pkg;

    // Default memory word width; a word is {note, len}
    localparam int DEF_DATA_WIDTH = 8;

    // Length field occupies the low bits, note code sits directly above it
    localparam int LEN_WIDTH = 3;
    localparam int NOTE_LSB  = LEN_WIDTH;

    // Note code meaning silence
    localparam int REST_NOTE = 0;

    // Playback FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REWIND = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } play_state_t;

endpackage

// File: rtl/playback_beat_timer.sv
// Beat timer for note playback: counts clock ticks within a beat, pulses at
// each beat boundary, tracks the remaining beats of the current note and holds
// everything while run is low (pause or not playing).
module playback_beat_timer
    import memory_playback_seq_pkg::*;
#(
    parameter int TICKS_PER_BEAT = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_beats,
    input  logic                 run,
    output logic                 beat_pulse,
    output logic                 last_beat
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    logic [TICK_W-1:0]    tick_reg;
    // Beats still to play after the current one (len field, so 0 = last beat)
    logic [LEN_WIDTH-1:0] beats_reg;

    assign beat_pulse = run && (tick_reg == TICK_LAST);
    assign last_beat  = (beats_reg == '0);

    // Tick counter and remaining-beat counter; load restarts a fresh note
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg  <= '0;
            beats_reg <= '0;
        end else if (load) begin
            tick_reg  <= '0;
            beats_reg <= load_beats;
        end else if (run) begin
            if (tick_reg == TICK_LAST) begin
                tick_reg <= '0;
                if (!last_beat) begin
                    beats_reg <= beats_reg - 1'b1;
                end
            end else begin
                tick_reg <= tick_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_playback_seq.sv
// Playback sequencer: rewinds the music memory, fetches words one by one,
// decodes {note, len}, sounds each note for len+1 beats followed by a muted
// gap, and stops on the all-ones END word.
// Optional feature macro PLAYBACK_LOOP_EN: the END word rewinds and replays
// the song forever instead of entering DONE.
module memory_playback_seq
    import memory_playback_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 1_000_000,
    parameter int READ_TIMEOUT   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           pause,
    output logic                           mem_read_en,
    output logic                           mem_read_rst,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    input  logic                           mem_ready,
    output logic [DATA_WIDTH-NOTE_LSB-1:0] note_out,
    output logic                           note_valid,
    output logic                           beat_pulse,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_error
);

    localparam int NOTE_W = DATA_WIDTH - NOTE_LSB;
    localparam int WAIT_W = $clog2(READ_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);

    localparam logic [DATA_WIDTH-1:0] END_WORD  = '1;
    localparam logic [NOTE_W-1:0]     REST      = NOTE_W'(REST_NOTE);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    play_state_t          state_reg, state_next;
    logic [NOTE_W-1:0]    note_reg, note_next;
    logic                 rd_error_reg, rd_error_next;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;

    logic [NOTE_W-1:0]    word_note;
    logic [LEN_WIDTH-1:0] word_len;
    logic                 timer_load;
    logic                 timer_run;
    logic                 timer_beat;
    logic                 timer_last;

    // Split the memory word into its note and length fields
    for (genvar gi = 0; gi < NOTE_W; gi++) begin : g_note_field
        assign word_note[gi] = mem_data[NOTE_LSB + gi];
    end
    for (genvar gi = 0; gi < LEN_WIDTH; gi++) begin : g_len_field
        assign word_len[gi] = mem_data[gi];
    end

    // Beat timing only advances while a note is playing and not paused
    assign timer_run = (state_reg == ST_PLAY) && !pause;

    playback_beat_timer #(
        .TICKS_PER_BEAT (TICKS_PER_BEAT)
    ) u_beat_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_beats (word_len),
        .run        (timer_run),
        .beat_pulse (timer_beat),
        .last_beat  (timer_last)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            note_reg     <= '0;
            rd_error_reg <= 1'b0;
            wait_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            note_reg     <= note_next;
            rd_error_reg <= rd_error_next;
            wait_cnt_reg <= wait_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
        end
    end

    // Next-state logic and memory strobes; stop overrides everything this cycle
    always_comb begin
        state_next    = state_reg;
        note_next     = note_reg;
        rd_error_next = rd_error_reg;
        wait_cnt_next = wait_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        mem_read_en   = 1'b0;
        mem_read_rst  = 1'b0;
        timer_load    = 1'b0;

        if (stop) begin
            state_next = ST_IDLE;
            note_next  = REST;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next    = ST_REWIND;
                        rd_error_next = 1'b0;
                        note_next     = REST;
                    end
                end
                ST_REWIND: begin
                    mem_read_rst = 1'b1;
                    state_next   = ST_FETCH;
                end
                ST_FETCH: begin
                    mem_read_en   = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        if (mem_data == END_WORD) begin
                            note_next = REST;
`ifdef PLAYBACK_LOOP_EN
                            state_next = ST_REWIND;
`else
                            state_next = ST_DONE;
`endif
                        end else begin
                            note_next  = word_note;
                            timer_load = 1'b1;
                            state_next = ST_PLAY;
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        rd_error_next = 1'b1;
                        note_next     = REST;
                        state_next    = ST_IDLE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (timer_beat && timer_last) begin
                        gap_cnt_next = '0;
                        state_next   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!pause) begin
                        if (gap_cnt_reg == GAP_LAST) begin
                            state_next = ST_FETCH;
                        end else begin
                            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    note_next  = REST;
                end
            endcase
        end
    end

    assign note_out   = note_reg;
    assign note_valid = (state_reg == ST_PLAY) && !pause && (note_reg != REST);
    assign beat_pulse = timer_beat;
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done       = (state_reg == ST_DONE);
    assign rd_error   = rd_error_reg;

endmodule

// File: tb/tb_memory_playback_seq.sv
// Bench for memory_playback_seq: a memory responder with per-word ready delay,
// and an expected per-cycle trace built from the song at note/beat level.
module tb_memory_playback_seq;

    localparam int TPB = 4;
    localparam int GAP = 2;
    localparam int TO  = 5;
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic       mem_read_en, mem_read_rst;
    logic [7:0] mem_data = 8'h00;
    logic       mem_ready = 1'b0;
    logic [4:0] note_out;
    logic       note_valid, beat_pulse, busy, done, rd_error;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_playback_seq #(
        .DATA_WIDTH     (8),
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP),
        .READ_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .mem_read_en  (mem_read_en),
        .mem_read_rst (mem_read_rst),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .note_out     (note_out),
        .note_valid   (note_valid),
        .beat_pulse   (beat_pulse),
        .busy         (busy),
        .done         (done),
        .rd_error     (rd_error)
    );

    // ---------------- memory unit model ----------------
    logic [7:0] mem [0:15];
    int         dly [0:15];
    int         pa  [0:15];
    int         pl  [0:15];
    bit         mem_dead = 1'b0;
    int         ptr = 0;
    bit         pend = 1'b0;
    int         pcnt = 0;
    bit         en_s = 1'b0, rst_s = 1'b0;

    always @(negedge clk) begin
        en_s  = mem_read_en;
        rst_s = mem_read_rst;
    end

    always @(posedge clk) begin
        #1;
        mem_ready = 1'b0;
        if (rst_s) ptr = 0;
        if (en_s && !mem_dead) begin
            pend = 1'b1;
            pcnt = dly[ptr];
        end
        if (pend) begin
            if (pcnt == 0) begin
                mem_ready = 1'b1;
                mem_data  = mem[ptr];
                ptr       = (ptr + 1) % 16;
                pend      = 1'b0;
            end else begin
                pcnt--;
            end
        end
    end

    // ---------------- expected trace ----------------
    typedef struct packed {
        logic       pause;
        logic       en;
        logic       rrst;
        logic       nv;
        logic       bp;
        logic       busy;
        logic       dn;
        logic       rerr;
        logic       chk_note;
        logic [4:0] note;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(input bit busy_v);
        exp_t e;
        e = '0;
        e.busy = busy_v;
        return e;
    endfunction

    task automatic push_play(input int i);
        exp_t e;
        logic [7:0] w;
        int total;
        w = mem[i];
        total = (int'(w[2:0]) + 1) * TPB;
        for (int c = 0; c < total; c++) begin
            if (c == pa[i]) begin
                for (int p = 0; p < pl[i]; p++) begin
                    e = mk(1); e.pause = 1; e.chk_note = 1; e.note = w[7:3];
                    q.push_back(e);
                end
            end
            e = mk(1); e.chk_note = 1; e.note = w[7:3];
            e.nv = (w[7:3] != 5'd0);
            e.bp = ((c + 1) % TPB == 0);
            q.push_back(e);
        end
    endtask

    task automatic push_fetch_wait(input int i);
        exp_t e;
        e = mk(1); e.en = 1; q.push_back(e);
        for (int d = 0; d <= dly[i]; d++) q.push_back(mk(1));
    endtask

    // Song in mem[] terminated by 0xFF
    task automatic build_song();
        exp_t e;
        q.delete();
        e = mk(1); e.rrst = 1; q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            push_fetch_wait(i);
            if (mem[i] == 8'hFF) begin
                if (LOOP) begin
                    e = mk(1); e.rrst = 1; q.push_back(e);
                    push_fetch_wait(0);
                    if (mem[0] != 8'hFF) push_play(0);
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        e = mk(0); e.dn = 1; e.chk_note = 1; e.note = 5'd0;
                        q.push_back(e);
                    end
                end
                break;
            end
            $display("word %02h: note=%0d beats=%0d ready_delay=%0d pause_at=%0d pause_len=%0d",
                     mem[i], mem[i][7:3], int'(mem[i][2:0]) + 1, dly[i], pa[i], pl[i]);
            push_play(i);
            for (int g = 0; g < GAP; g++) q.push_back(mk(1));
        end
    endtask

    // Read never answered: REWIND, FETCH, TO waits, then IDLE with error
    task automatic build_timeout();
        exp_t e;
        q.delete();
        e = mk(1); e.rrst = 1; q.push_back(e);
        e = mk(1); e.en = 1; q.push_back(e);
        for (int d = 0; d < TO; d++) q.push_back(mk(1));
        e = mk(0); e.rerr = 1; e.chk_note = 1; e.note = 5'd0; q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Called at posedge+1 with the DUT in the state of entry 0
    task automatic run_q(input int limit, input string name);
        for (int k = 0; k < q.size() && k < limit; k++) begin
            pause = q[k].pause;
            #1;
            chk($sformatf("%s[%0d].rd_en", name, k), mem_read_en, q[k].en);
            chk($sformatf("%s[%0d].rd_rst", name, k), mem_read_rst, q[k].rrst);
            chk($sformatf("%s[%0d].note_valid", name, k), note_valid, q[k].nv);
            chk($sformatf("%s[%0d].beat_pulse", name, k), beat_pulse, q[k].bp);
            chk($sformatf("%s[%0d].busy", name, k), busy, q[k].busy);
            chk($sformatf("%s[%0d].done", name, k), done, q[k].dn);
            chk($sformatf("%s[%0d].rd_error", name, k), rd_error, q[k].rerr);
            if (q[k].chk_note) chk($sformatf("%s[%0d].note_out", name, k), note_out, q[k].note);
            @(posedge clk); #1;
        end
        pause = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic clear_song();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'hFF; dly[i] = 0; pa[i] = -1; pl[i] = 0;
        end
    endtask

    task automatic play_song(input string name);
        build_song();
        do_start();
        run_q(q.size(), name);
        if (LOOP) do_stop();
    endtask

    task automatic check_idle_zero(input string name);
        chk({name, ".rd_en"}, mem_read_en, 0);
        chk({name, ".rd_rst"}, mem_read_rst, 0);
        chk({name, ".note_out"}, note_out, 0);
        chk({name, ".note_valid"}, note_valid, 0);
        chk({name, ".beat_pulse"}, beat_pulse, 0);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".done"}, done, 0);
    endtask

    initial begin
        clear_song();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_zero("reset");
        chk("reset.rd_error", rd_error, 0);

        // Note 5 for three beats, then END
        clear_song();
        mem[0] = 8'h2A;
        play_song("song_2a");

        // Rest word: silent for two beats
        clear_song();
        mem[0] = 8'h01; mem[1] = 8'h2A;
        play_song("song_rest");

        // Pause three cycles in the middle of a note
        clear_song();
        mem[0] = 8'h2A; pa[0] = 5; pl[0] = 3;
        play_song("song_pause");

        // Memory never answers: timeout, then start clears the error
        mem_dead = 1'b1;
        build_timeout();
        do_start();
        run_q(q.size(), "timeout");
        mem_dead = 1'b0;
        clear_song();
        mem[0] = 8'h13; dly[0] = 2;
        play_song("after_timeout");

        // Randomised songs
        for (int s = 0; s < 8; s++) begin
            int nw;
            clear_song();
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) begin
                mem[i] = 8'($urandom_range(0, 254));
                dly[i] = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) begin
                    pa[i] = $urandom_range(1, (int'(mem[i][2:0]) + 1) * TPB - 1);
                    pl[i] = $urandom_range(1, 3);
                end
            end
            dly[nw] = $urandom_range(0, 3);
            play_song($sformatf("rand%0d", s));
        end

        // stop with start while FETCH drives read_en: strobe suppressed, back to IDLE
        clear_song();
        mem[0] = 8'h2A;
        build_song();
        do_start();
        run_q(1, "stop_fetch");
        stop = 1'b1; start = 1'b1;
        #1 chk("stop_fetch.rd_en_same_cycle", mem_read_en, 0);
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check_idle_zero("stop_fetch.after");

        // stop with start mid-PLAY: stop wins
        build_song();
        do_start();
        run_q(8, "stop_play");
        stop = 1'b1; start = 1'b1;
        #1 chk("stop_play.rd_en_same_cycle", mem_read_en, 0);
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check_idle_zero("stop_play.after");
        @(posedge clk); #1;
        chk("stop_play.still_idle", busy, 0);
        $display("stop with start: returned to IDLE");

        // Timeout again, then rst clears the sticky error
        mem_dead = 1'b1;
        build_timeout();
        do_start();
        run_q(q.size(), "timeout2");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_clears.rd_error", rd_error, 0);

        // Reset in the middle of WAIT
        do_start();
        run_q(3, "rst_wait");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("rst_wait.after");
        chk("rst_wait.rd_error", rd_error, 0);
        mem_dead = 1'b0;
        $display("reset mid-WAIT: outputs cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
